// File: rtl/cvxif_mad_pkg.sv
// cvxif_mad_pkg: shared types and encodings for the mad/made.v execution unit
package cvxif_mad_pkg;
  localparam int MAD_XLEN = 32;
  localparam int MAD_ID_W = 4;
  localparam logic [2:0] FUNCT3_MAD = 3'b000;
  localparam logic [2:0] FUNCT3_MADE = 3'b001;
  localparam logic [6:0] OPCODE_MAD = 7'b0110011;
  localparam logic [1:0] FUNCT2_MAD = 2'b11;
  typedef enum logic [1:0] {IDLE, MUL, ADD, RESP} state_t;
  typedef struct packed {
    logic [MAD_ID_W-1:0] id;
    logic [MAD_XLEN-1:0] data;
    logic [4:0] rd;
    logic we;
  } res_t;
  // R4-type encoding with fixed source register fields x1, x2, x3
  function automatic logic [31:0] mad_instr(input logic [2:0] funct3, input logic [4:0] rd);
    return {5'd3, FUNCT2_MAD, 5'd2, 5'd1, funct3, rd, OPCODE_MAD};
  endfunction
endpackage

// File: rtl/cvxif_mad_mul_iter.sv
// cvxif_mad_mul_iter: iterative radix-2^BitsPerCycle unsigned multiplier
module cvxif_mad_mul_iter #(
  parameter int XLEN = 32,
  parameter int BitsPerCycle = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);
  localparam int N = XLEN / BitsPerCycle;
  localparam int CW = $clog2(N + 1);
  if (BitsPerCycle < 1 || BitsPerCycle > XLEN || XLEN % BitsPerCycle != 0)
    $error("BitsPerCycle must divide XLEN");
  logic [XLEN-1:0] a;
  logic [2*XLEN-1:0] b;
  logic [CW-1:0] cnt;
  // done marks the cycle that retires the last digit
  assign done = busy && cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      a <= '0;
      b <= '0;
      cnt <= '0;
      product <= '0;
    end else if (start) begin
      busy <= 1'b1;
      a <= op_a;
      b <= {{XLEN{1'b0}}, op_b};
      cnt <= CW'(N);
      product <= '0;
    end else if (busy) begin
      product <= product + b * (2*XLEN)'(a[BitsPerCycle-1:0]);
      a <= a >> BitsPerCycle;
      b <= b << BitsPerCycle;
      cnt <= cnt - 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/cvxif_mad_unit.sv
// cvxif_mad_unit: CV-X-IF execution stage for mad/made.v (rs1*rs2 + rs3, low or high half)
module cvxif_mad_unit
  import cvxif_mad_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IdWidth = 4,
  parameter int BitsPerCycle = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [XLEN-1:0]    issue_rs3_i,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);
  if (XLEN != MAD_XLEN || IdWidth != MAD_ID_W) $error("result struct width mismatch");
  state_t state;
  res_t res;
  logic committed, sel_hi, mul_busy, mul_done;
  logic issue_fire, result_fire, commit_hit, kill_hit, unused_bits;
  logic [XLEN-1:0] rs3;
  logic [2*XLEN-1:0] product, sum;
  assign issue_ready_o = state == IDLE;
  assign issue_fire = issue_valid_i && issue_ready_o;
  assign result_valid_o = state == RESP && committed;
  assign result_fire = result_valid_o && result_ready_i;
  assign commit_hit = commit_valid_i && !commit_kill_i && commit_id_i == res.id && state != IDLE;
  assign kill_hit = commit_valid_i && commit_kill_i && commit_id_i == res.id && state != IDLE;
  assign sum = product + {{XLEN{1'b0}}, rs3};
  assign result_id_o = res.id;
  assign result_data_o = res.data;
  assign result_rd_o = res.rd;
  assign result_we_o = res.we;
  assign unused_bits = ^{issue_instr_i[31:13], issue_instr_i[6:0], mul_busy};
  cvxif_mad_mul_iter #(.XLEN(XLEN), .BitsPerCycle(BitsPerCycle)) u_mul (
    .clk(clk_i),
    .rst(rst_i),
    .start(issue_fire),
    .op_a(issue_rs1_i),
    .op_b(issue_rs2_i),
    .busy(mul_busy),
    .done(mul_done),
    .product(product)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      res <= '0;
      committed <= 1'b0;
      sel_hi <= 1'b0;
      rs3 <= '0;
    end else begin
      case (state)
        IDLE: if (issue_fire) begin
          state <= MUL;
          res.id <= issue_id_i;
          res.rd <= issue_instr_i[11:7];
          rs3 <= issue_rs3_i;
          sel_hi <= issue_instr_i[12];
          committed <= commit_valid_i && !commit_kill_i && commit_id_i == issue_id_i;
        end
        MUL: state <= kill_hit ? IDLE : mul_done ? ADD : MUL;
        ADD: begin
          state <= kill_hit ? IDLE : RESP;
          res.data <= sel_hi ? sum[2*XLEN-1:XLEN] : sum[XLEN-1:0];
          res.we <= !kill_hit;
        end
        RESP: if (result_fire || kill_hit) begin
          state <= IDLE;
          res.we <= 1'b0;
        end
      endcase
      if (commit_hit) committed <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cvxif_mad_unit.sv
// tb_cvxif_mad_unit: scoreboard bench for cvxif_mad_unit
module tb_cvxif_mad_unit;
  import cvxif_mad_pkg::*;
  logic clk = 0, rst_i = 1;
  logic issue_valid_i = 0, commit_valid_i = 0, commit_kill_i = 0, result_ready_i = 1;
  logic issue_ready_o, result_valid_o, result_we_o;
  logic [31:0] issue_instr_i = 0, issue_rs1_i = 0, issue_rs2_i = 0, issue_rs3_i = 0, result_data_o;
  logic [3:0] issue_id_i = 0, commit_id_i = 0, result_id_o;
  logic [4:0] result_rd_o;
  int total = 0, passed = 0;
  typedef struct {logic [3:0] id; logic [31:0] data; logic [4:0] rd;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  cvxif_mad_unit dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i), .issue_rs3_i(issue_rs3_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask

  function automatic logic [31:0] model(input logic hi, input logic [31:0] a, b, c);
    logic [63:0] s;
    s = {32'b0, a} * {32'b0, b} + {32'b0, c};
    return hi ? s[63:32] : s[31:0];
  endfunction

  always @(negedge clk) begin
    if (result_valid_o && result_ready_i) begin
      if (exp_q.size() == 0) chk("spurious_result", 64'(result_valid_o), 0);
      else begin
        e = exp_q.pop_front();
        chk("res_data", 64'(result_data_o), 64'(e.data));
        chk("res_id", 64'(result_id_o), 64'(e.id));
        chk("res_rd", 64'(result_rd_o), 64'(e.rd));
        chk("res_we", 64'(result_we_o), 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    issue_valid_i = 0;
    commit_valid_i = 0;
    commit_kill_i = 0;
  endtask

  task automatic issue_start(input logic [2:0] f3, input logic [31:0] a, b, c,
                             input logic [4:0] rd, input logic [3:0] id, input logic commit_now);
    issue_valid_i = 1;
    issue_instr_i = mad_instr(f3, rd);
    issue_id_i = id;
    issue_rs1_i = a;
    issue_rs2_i = b;
    issue_rs3_i = c;
    commit_valid_i = commit_now;
    commit_id_i = id;
    commit_kill_i = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) step();
    chk(tag, 64'(exp_q.size()), 0);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, b, c, input logic [4:0] rd,
                        input logic [3:0] id, input logic [31:0] expd, input int commit_at);
    issue_start(f3, a, b, c, rd, id, commit_at == 0);
    exp_q.push_back('{id, expd, rd});
    for (int k = 1; k < 200 && exp_q.size() != 0; k++) begin
      step();
      clr();
      if (k == commit_at) begin
        commit_valid_i = 1;
        commit_id_i = id;
      end
    end
    chk("op_drain", 64'(exp_q.size()), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 64'(issue_ready_o), 1);
    chk({tag, "_valid"}, 64'(result_valid_o), 0);
    chk({tag, "_id"}, 64'(result_id_o), 0);
    chk({tag, "_data"}, 64'(result_data_o), 0);
    chk({tag, "_rd"}, 64'(result_rd_o), 0);
    chk({tag, "_we"}, 64'(result_we_o), 0);
  endtask

  initial begin
    logic [31:0] a, b, c;
    logic [2:0] f3;
    step();
    step();
    rst_i = 0;
    chk_reset("reset");
    // basic mad with commit in cycle 2, result in cycle 18
    issue_start(FUNCT3_MAD, 3, 5, 7, 10, 2, 0);
    exp_q.push_back('{4'd2, 32'd22, 5'd10});
    for (int k = 1; k <= 18; k++) begin
      step();
      clr();
      if (k == 2) begin
        commit_valid_i = 1;
        commit_id_i = 2;
      end
      chk($sformatf("busy_c%0d", k), 64'(issue_ready_o), 0);
      chk($sformatf("valid_c%0d", k), 64'(result_valid_o), 64'(k == 18));
    end
    step();
    chk("ready_after_result", 64'(issue_ready_o), 1);
    chk("basic_drain", 64'(exp_q.size()), 0);
    // boundary patterns
    run_op(FUNCT3_MADE, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5, 3, 32'hFFFFFFFE, 0);
    run_op(FUNCT3_MAD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 6, 4, 32'h00000002, 0);
    run_op(FUNCT3_MADE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 7, 8, 32'hFFFFFFFF, 3);
    run_op(FUNCT3_MAD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 31, 15, 32'h00000000, 17);
    run_op(3'b111, 32'h00010000, 32'h00010000, 0, 1, 9, 32'h00000001, 0);
    // kill of the in-flight id
    issue_start(FUNCT3_MAD, 11, 12, 13, 2, 5, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      clr();
      if (k == 5) begin
        commit_valid_i = 1;
        commit_kill_i = 1;
        commit_id_i = 5;
      end
    end
    step();
    clr();
    chk("kill_idle", 64'(issue_ready_o), 1);
    run_op(FUNCT3_MAD, 6, 7, 8, 4, 1, 50, 0);
    // kill of a different id is ignored
    issue_start(FUNCT3_MADE, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 12, 5, 1);
    exp_q.push_back('{4'd5, model(1, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F), 5'd12});
    for (int k = 1; k <= 5; k++) begin
      step();
      clr();
      if (k == 5) begin
        commit_valid_i = 1;
        commit_kill_i = 1;
        commit_id_i = 6;
      end
    end
    step();
    clr();
    chk("kill_other_busy", 64'(issue_ready_o), 0);
    drain("kill_other_drain", 40);
    // late commit and backpressure
    result_ready_i = 0;
    issue_start(FUNCT3_MAD, 100, 200, 300, 9, 7, 0);
    exp_q.push_back('{4'd7, 32'd20300, 5'd9});
    for (int k = 1; k <= 25; k++) begin
      step();
      clr();
      if (k == 25) begin
        chk("late_no_valid", 64'(result_valid_o), 0);
        commit_valid_i = 1;
        commit_id_i = 7;
      end
    end
    step();
    clr();
    for (int k = 0; k < 10; k++) begin
      chk("hold_valid", 64'(result_valid_o), 1);
      chk("hold_data", 64'(result_data_o), 20300);
      chk("hold_id", 64'(result_id_o), 7);
      chk("hold_rd", 64'(result_rd_o), 9);
      chk("hold_we", 64'(result_we_o), 1);
      chk("hold_busy", 64'(issue_ready_o), 0);
      step();
    end
    result_ready_i = 1;
    step();
    chk("bp_idle", 64'(issue_ready_o), 1);
    chk("bp_drain", 64'(exp_q.size()), 0);
    // reset mid-MUL aborts
    issue_start(FUNCT3_MADE, 32'hDEADBEEF, 32'hCAFEF00D, 5, 17, 3, 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      clr();
      if (k == 8) rst_i = 1;
    end
    step();
    rst_i = 0;
    chk_reset("midrst");
    for (int k = 0; k < 25; k++) begin
      step();
      chk("rst_no_result", 64'(result_valid_o), 0);
    end
    // random operations, some with funct3[2:1] set and late commits
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      c = $urandom;
      f3 = 3'($urandom);
      run_op(f3, a, b, c, 5'($urandom), 4'($urandom), model(f3[0], a, b, c), $urandom_range(0, 30));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cvxif_mad_unit.md
Name: cvxif_mad_unit

Overview:
- Execution stage downstream of the CV-X-IF coprocessor issue decoder.
- Consumes issue requests the decoder has already accepted for the `mad` (funct3=000) and `made.v` (funct3=001) R4-type instructions, opcode 0110011, funct2=11.
- Computes the unsigned sum rs1*rs2 + rs3 with an iterative multiplier and returns the low or high half through the CV-X-IF result handshake.
- Holds one instruction at a time and honours commit/kill from the core.

Parameters:
- XLEN, 32, operand and result width.
- IdWidth, 4, instruction id width; matches X_ID_WIDTH.
- BitsPerCycle, 2, multiplier bits retired per cycle; must divide XLEN, range 1..XLEN.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- issue_valid_i  in  1  accepted mad/made.v instruction presented
- issue_ready_o  out  1  unit can take an instruction
- issue_instr_i  in  32  instruction word
- issue_id_i  in  IdWidth  instruction id
- issue_rs1_i / issue_rs2_i / issue_rs3_i  in  XLEN each  register operands
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  IdWidth  committed id
- commit_kill_i  in  1  1 = discard instruction commit_id_i
- result_valid_o  out  1  result available
- result_ready_i  in  1  core accepts result
- result_id_o  out  IdWidth  id of result
- result_data_o  out  XLEN  result value
- result_rd_o  out  5  destination register, instr[11:7]
- result_we_o  out  1  write enable, always 1 while result_valid_o

Behaviour:
- Clock and reset: single clock clk_i; reset is synchronous and active-high on rst_i.
- Reset values: state IDLE; issue_ready_o=1; result_valid_o=0; result_id_o=0; result_data_o=0; result_rd_o=0; result_we_o=0; committed flag cleared.
- Reset mid-operation aborts the instruction with no result. Outputs take reset values in the cycle after rst_i is sampled high.
- FSM states IDLE, MUL, ADD, RESP.
- IDLE:
  - issue_ready_o=1.
  - On issue_valid_i, latch operands, id, rd and funct3[0] (0=low half, 1=high half; funct3[2:1] ignored).
  - Clear the product accumulator, load the iteration counter with N=XLEN/BitsPerCycle, go to MUL.
- MUL:
  - Each cycle, add the next BitsPerCycle-bit digit of rs1 times rs2 into a 2*XLEN accumulator and decrement the counter.
  - After N cycles go to ADD.
- ADD: S = P + zero-extend(rs3), mod 2^(2*XLEN). Select S[XLEN-1:0] or S[2XLEN-1:XLEN]. Go to RESP.
- RESP:
  - result_valid_o = committed flag. result_* outputs are stable while valid and not ready.
  - On handshake go to IDLE.
- Timing: issue_ready_o=0 in every non-IDLE state. With the issue handshake in cycle 0, the earliest result_valid_o is cycle N+2 (cycle 18 at the defaults). The next issue handshake is possible in the cycle after the result handshake.
- Commit tracking:
  - commit_valid_i with commit_id_i equal to the stored id and kill=0 sets the committed flag.
  - This also applies when the commit coincides with the issue handshake and matches issue_id_i.
  - A commit arriving in RESP raises result_valid_o the next cycle.
- Kill:
  - commit_valid_i, kill=1 and matching id in MUL, ADD or RESP before the handshake: go to IDLE next cycle and produce no result.
  - If kill coincides with a completed result handshake, the result counts as delivered and the kill is ignored.
- Commits or kills with non-matching id, or arriving in IDLE without a simultaneous matching issue, are ignored.
- Arithmetic is unsigned throughout; no exceptions are raised.

Decomposition:
- Shared package cvxif_mad_pkg holds:
  - state enum (IDLE, MUL, ADD, RESP);
  - funct3 constants FUNCT3_MAD=3'b000 and FUNCT3_MADE=3'b001;
  - OPCODE_MAD=7'b0110011 and FUNCT2_MAD=2'b11;
  - the result struct (id, data, rd, we).
- One sub-module, cvxif_mad_mul_iter: iterative radix-2^BitsPerCycle multiplier with start/busy/done and a 2*XLEN product output. The top level owns the FSM, commit/kill and the adder.

Test Plan (XLEN=32, BitsPerCycle=2):
- mad, rs1=3, rs2=5, rs3=7, rd=10, id=2; commit (kill=0) in cycle 2; result_ready_i=1 -> result_valid_o in cycle 18, data=22, rd=10, id=2, we=1; issue_ready_o=0 in cycles 1..18.
- rs1=rs2=0xFFFFFFFF, rs3=1 -> made.v returns 0xFFFFFFFE; mad returns 0x00000002.
- Carry boundary: rs1=rs2=rs3=0xFFFFFFFF -> S=0xFFFFFFFF00000000; made.v returns 0xFFFFFFFF, mad returns 0x00000000.
- Kill: issue id=5, kill id=5 in cycle 5 -> IDLE in cycle 6, no result_valid_o ever; a new issue in cycle 6 completes normally. A kill of id=6 in the same scenario has no effect.
- Late commit and backpressure: commit in cycle 25 -> result_valid_o first high in cycle 26. Hold result_ready_i=0 for 10 cycles -> all result_* outputs stable; the handshake on ready returns the unit to IDLE.
- rst_i high in cycle 8 mid-MUL -> cycle 9 shows all reset values, with no result for the aborted instruction.
